knn_vote_selector: RTL

- Downstream consumer of the distance calculator in the KNN classifier.
- Accepts one (distance, data_type) result per `done` pulse over a classification run of N_SAMPLES training samples.
- Keeps a sorted list of the K smallest distances, then runs a sequential majority vote over the stored types.
- Emits the classified type with a one-cycle `result_valid` pulse.

---
 rtl/knn_vote_selector.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/knn_vote_selector.sv
// KNN vote selector: keeps the K nearest (distance, type) results of a run, then majority-votes.
// Latency: result_valid_o pulses in the cycle beginning C+1 edges after the edge sampling the final done_i.
// Backpressure: none; one sample accepted per done_i strobe, start_i aborts any run in progress.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               pulse that begins (or restarts) a classification run
//   distance_i, data_type_i, done_i   one upstream result per done_i strobe
//   result_type_o, result_valid_o     winning class and its one-cycle valid pulse
//   busy_o                high in COLLECT, VOTE and DONE
// Optional build macro: KNN_TIE_NEAREST_EN (vote ties go to the class owning the nearest neighbour).
module knn_vote_selector #(
    parameter int W         = 16,
    parameter int TYPE_W    = 2,
    parameter int K         = 5,
    parameter int N_SAMPLES = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [W-1:0]      distance_i,
    input  logic [TYPE_W-1:0] data_type_i,
    input  logic              done_i,
    output logic [TYPE_W-1:0] result_type_o,
    output logic              result_valid_o,
    output logic              busy_o
);

    localparam int                C         = 1 << TYPE_W;
    localparam int                CNT_W     = $clog2(K + 1);
    localparam int                SC_W      = $clog2(N_SAMPLES + 1);
    localparam logic [W-1:0]      DIST_INIT = {1'b0, {(W-1){1'b1}}};
    localparam logic [TYPE_W-1:0] LAST_CLS  = TYPE_W'(C - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_VOTE,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [W-1:0]        dist_q [K];
    logic [TYPE_W-1:0]   type_q [K];
    logic                vld_q  [K];
    logic [SC_W-1:0]     smp_cnt_q;
    logic [TYPE_W-1:0]   vote_cls_q;
    logic [CNT_W-1:0]    best_cnt_q;
    logic [TYPE_W-1:0]   best_cls_q;
    logic [TYPE_W-1:0]   result_type_q;
    logic                result_valid_q;
    logic                busy_q;

    logic [W-1:0]        dist_d [K];
    logic [TYPE_W-1:0]   type_d [K];
    logic                vld_d  [K];
    logic [SC_W-1:0]     smp_cnt_d;
    logic                ins_found;
    logic [CNT_W-1:0]    ins_pos;
    logic [CNT_W-1:0]    vote_cnt;
    logic                vote_win;

`ifdef KNN_TIE_NEAREST_EN
    logic [CNT_W-1:0]    best_rank_q;
    logic [CNT_W-1:0]    vote_rank;
`endif

    assign result_type_o  = result_type_q;
    assign result_valid_o = result_valid_q;
    assign busy_o         = busy_q;
    assign smp_cnt_d      = smp_cnt_q + SC_W'(1);

    // Sorted insertion. Valid entries are always packed at the low indices, so the
    // first slot that is either empty or strictly farther is the insertion point;
    // the strict compare keeps earlier arrivals ahead of equal distances.
    always_comb begin
        ins_found = 1'b0;
        ins_pos   = '0;
        for (int j = 0; j < K; j++) begin
            if (!ins_found && (!vld_q[j] || (distance_i < dist_q[j]))) begin
                ins_found = 1'b1;
                ins_pos   = CNT_W'(j);
            end
        end
        for (int j = 0; j < K; j++) begin
            dist_d[j] = dist_q[j];
            type_d[j] = type_q[j];
            vld_d[j]  = vld_q[j];
        end
        if (ins_found) begin
            // Entries behind the insertion point move back one slot; the last one falls off.
            for (int j = 1; j < K; j++) begin
                if (CNT_W'(j) > ins_pos) begin
                    dist_d[j] = dist_q[j-1];
                    type_d[j] = type_q[j-1];
                    vld_d[j]  = vld_q[j-1];
                end
            end
            for (int j = 0; j < K; j++) begin
                if (CNT_W'(j) == ins_pos) begin
                    dist_d[j] = distance_i;
                    type_d[j] = data_type_i;
                    vld_d[j]  = 1'b1;
                end
            end
        end
    end

    // Population count of the class under evaluation this cycle.
    always_comb begin
        vote_cnt = '0;
        for (int j = 0; j < K; j++) begin
            if (vld_q[j] && (type_q[j] == vote_cls_q)) begin
                vote_cnt = vote_cnt + CNT_W'(1);
            end
        end
    end

`ifdef KNN_TIE_NEAREST_EN
    // Lowest list index holding the evaluated class; K means "absent".
    always_comb begin
        vote_rank = CNT_W'(K);
        for (int j = K - 1; j >= 0; j--) begin
            if (vld_q[j] && (type_q[j] == vote_cls_q)) begin
                vote_rank = CNT_W'(j);
            end
        end
    end

    always_comb begin
        vote_win = (vote_cnt > best_cnt_q);
        if ((vote_cnt == best_cnt_q) && (vote_cnt != '0) && (vote_rank < best_rank_q)) begin
            vote_win = 1'b1;
        end
    end
`else
    always_comb begin
        vote_win = (vote_cnt > best_cnt_q);
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= S_IDLE;
            smp_cnt_q      <= '0;
            vote_cls_q     <= '0;
            best_cnt_q     <= '0;
            best_cls_q     <= '0;
            result_type_q  <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
`ifdef KNN_TIE_NEAREST_EN
            best_rank_q    <= CNT_W'(K);
`endif
            for (int j = 0; j < K; j++) begin
                dist_q[j] <= DIST_INIT;
                type_q[j] <= '0;
                vld_q[j]  <= 1'b0;
            end
        end else begin
            result_valid_q <= 1'b0;
            if (start_i) begin
                // start_i wins over everything, including a same-cycle done_i.
                state_q   <= S_COLLECT;
                busy_q    <= 1'b1;
                smp_cnt_q <= '0;
                for (int j = 0; j < K; j++) begin
                    dist_q[j] <= DIST_INIT;
                    type_q[j] <= '0;
                    vld_q[j]  <= 1'b0;
                end
            end else begin
                case (state_q)
                    S_COLLECT: begin
                        if (done_i) begin
                            for (int j = 0; j < K; j++) begin
                                dist_q[j] <= dist_d[j];
                                type_q[j] <= type_d[j];
                                vld_q[j]  <= vld_d[j];
                            end
                            smp_cnt_q <= smp_cnt_d;
                            if (smp_cnt_d == SC_W'(N_SAMPLES)) begin
                                state_q    <= S_VOTE;
                                vote_cls_q <= '0;
                                best_cnt_q <= '0;
                                best_cls_q <= '0;
`ifdef KNN_TIE_NEAREST_EN
                                best_rank_q <= CNT_W'(K);
`endif
                            end
                        end
                    end
                    S_VOTE: begin
                        if (vote_win) begin
                            best_cnt_q <= vote_cnt;
                            best_cls_q <= vote_cls_q;
`ifdef KNN_TIE_NEAREST_EN
                            best_rank_q <= vote_rank;
`endif
                        end
                        if (vote_cls_q == LAST_CLS) begin
                            state_q <= S_DONE;
                        end else begin
                            vote_cls_q <= vote_cls_q + TYPE_W'(1);
                        end
                    end
                    S_DONE: begin
                        result_type_q  <= best_cls_q;
                        result_valid_q <= 1'b1;
                        state_q        <= S_IDLE;
                        busy_q         <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
